// File: rtl/switch_logic_debounced.sv
// -----------------------------------------------------------------------------
// switch_logic_debounced
//   Debounces N_SW data switches plus a mode switch, evaluates a sum-of-products
//   (SOP) and an implication-product (IMP) function over the debounced data
//   switches, and drives four registered LEDs in LIVE, HOLD or COUNT mode.
//   The debounced mode switch's rising edge steps the mode LIVE -> HOLD -> COUNT.
//
// Parameters
//   N_SW            data switch count (even, >= 2)
//   DEBOUNCE_LIMIT  consecutive stable cycles needed to accept a change (>= 1)
//
// Ports
//   i_Clk          system clock, rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_Switch       raw data switches (asynchronous)
//   i_Switch_Mode  raw mode switch (asynchronous)
//   o_LED_1..3     function / frozen / counter bits
//   o_LED_4        mode (HOLD) or overflow (COUNT) indicator
// -----------------------------------------------------------------------------
module switch_logic_debounced #(
  parameter int N_SW           = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic            i_Clk,
  input  logic            i_Rst_L,
  input  logic [N_SW-1:0] i_Switch,
  input  logic            i_Switch_Mode,
  output logic            o_LED_1,
  output logic            o_LED_2,
  output logic            o_LED_3,
  output logic            o_LED_4
);

  localparam int NB = N_SW + 1;
  localparam int H  = N_SW / 2;
  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  // Terminal count is LIMIT-1 so the accepting cycle is the LIMIT-th mismatch.
  localparam logic [CW-1:0] LIM_M1 = CW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    MODE_LIVE  = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_COUNT = 2'd2
  } mode_t;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_db;
  logic [CW-1:0] r_db_cnt [NB];

  logic [N_SW-1:0] w_db_sw;
  logic            w_db_mode;
  logic            w_sop;
  logic            w_imp;

  logic            r_mode_prev;
  logic            r_sop_prev;
  logic            w_mode_rise;
  logic            w_sop_rise;

  mode_t           r_state;
  mode_t           w_state_next;
  logic [2:0]      r_ev_cnt;
  logic [2:0]      w_ev_cnt_next;
  logic            r_ovf;
  logic            w_ovf_next;
  logic [3:0]      r_led;
  logic [3:0]      w_led_next;

  assign w_raw = {i_Switch_Mode, i_Switch};

  // Synchroniser and debounce counter, one lane per switch.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == LIM_M1) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_db_sw   = r_db[N_SW-1:0];
  assign w_db_mode = r_db[N_SW];

  // Pair k uses a = d[k], b = d[k+H]; implication direction alternates with k.
  always_comb begin
    w_sop = 1'b0;
    w_imp = 1'b1;
    for (int unsigned k = 0; k < H; k++) begin
      w_sop = w_sop | (w_db_sw[k] & w_db_sw[k+H]);
      if (k % 2 == 0) begin
        w_imp = w_imp & (w_db_sw[k] | ~w_db_sw[k+H]);
      end else begin
        w_imp = w_imp & (w_db_sw[k+H] | ~w_db_sw[k]);
      end
    end
  end

  assign w_mode_rise = w_db_mode & ~r_mode_prev;
  assign w_sop_rise  = w_sop & ~r_sop_prev;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= MODE_LIVE;
      r_mode_prev <= 1'b0;
      r_sop_prev  <= 1'b0;
      r_ev_cnt    <= '0;
      r_ovf       <= 1'b0;
      r_led       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mode_prev <= w_db_mode;
      r_sop_prev  <= w_sop;
      r_ev_cnt    <= w_ev_cnt_next;
      r_ovf       <= w_ovf_next;
      r_led       <= w_led_next;
    end
  end

  // LEDs are computed from the next state so the LED change lands on the same
  // edge as the mode change; a mode edge takes priority over an SOP edge.
  always_comb begin
    w_state_next  = r_state;
    w_ev_cnt_next = r_ev_cnt;
    w_ovf_next    = r_ovf;
    w_led_next    = r_led;

    if (w_mode_rise) begin
      unique case (r_state)
        MODE_LIVE:  w_state_next = MODE_HOLD;
        MODE_HOLD: begin
          w_state_next  = MODE_COUNT;
          w_ev_cnt_next = '0;
          w_ovf_next    = 1'b0;
        end
        MODE_COUNT: w_state_next = MODE_LIVE;
        default:    w_state_next = MODE_LIVE;
      endcase
    end else if (r_state == MODE_COUNT && w_sop_rise) begin
      w_ev_cnt_next = r_ev_cnt + 3'd1;
      if (r_ev_cnt == 3'd7) begin
        w_ovf_next = 1'b1;
      end
    end

    unique case (w_state_next)
      MODE_LIVE:  w_led_next = {1'b0, w_imp, w_sop, w_sop | w_imp};
      MODE_HOLD:  w_led_next = {1'b1, r_led[2:0]};
      MODE_COUNT: w_led_next = {w_ovf_next, w_ev_cnt_next};
      default:    w_led_next = '0;
    endcase
  end

  assign o_LED_1 = r_led[0];
  assign o_LED_2 = r_led[1];
  assign o_LED_3 = r_led[2];
  assign o_LED_4 = r_led[3];

endmodule

// File: tb/tb_switch_logic_debounced.sv
// -----------------------------------------------------------------------------
// tb_switch_logic_debounced
//   Directed bench for switch_logic_debounced with N_SW=4, DEBOUNCE_LIMIT=4
//   (raw edge to LED = 7 cycles). LEDs are compared as {LED4,LED3,LED2,LED1}.
// -----------------------------------------------------------------------------
module tb_switch_logic_debounced;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       sw_mode;
  logic       led1, led2, led3, led4;
  logic [3:0] leds;

  int checks = 0;
  int errors = 0;

  switch_logic_debounced #(
    .N_SW          (4),
    .DEBOUNCE_LIMIT(4)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Switch     (sw),
    .i_Switch_Mode(sw_mode),
    .o_LED_1      (led1),
    .o_LED_2      (led2),
    .o_LED_3      (led3),
    .o_LED_4      (led4)
  );

  assign leds = {led4, led3, led2, led1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode press: change lands at +7; held and released long enough to debounce.
  task automatic press_mode(input string tag, input logic [3:0] exp);
    sw_mode = 1'b1;
    tick(7);
    check_eq(tag, leds, exp);
    tick(3);
    sw_mode = 1'b0;
    tick(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    sw      = 4'b0000;
    sw_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_leds", leds, 4'b0000);
    rst_n = 1'b1;

    // All-zero switches in LIVE: SOP=0, IMP=1.
    tick(1);
    check_eq("live_zero", leds, 4'b0101);

    // LIVE truth table and exact latency.
    sw = 4'b0101;
    tick(6);
    check_eq("live_0101_c6", leds, 4'b0101);
    tick(1);
    check_eq("live_0101_c7", leds, 4'b0111);
    sw = 4'b0100;
    tick(6);
    check_eq("live_0100_c6", leds, 4'b0111);
    tick(1);
    check_eq("live_0100_c7", leds, 4'b0000);
    tick(5);

    // Glitch rejection: 3-cycle pulse on bit 0.
    sw = 4'b0101;
    tick(3);
    sw = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_eq("glitch3", leds, 4'b0000);
    end
    // 4-cycle pulse is accepted, and its release also debounces.
    sw = 4'b0101;
    tick(4);
    sw = 4'b0100;
    tick(3);
    check_eq("pulse4_on", leds, 4'b0111);
    tick(4);
    check_eq("pulse4_off", leds, 4'b0000);
    tick(5);

    // HOLD freezes LED1..3 and ignores switches.
    sw = 4'b0101;
    tick(10);
    check_eq("pre_hold", leds, 4'b0111);
    press_mode("enter_hold", 4'b1111);
    sw = 4'b0000;
    tick(15);
    check_eq("hold_frozen", leds, 4'b1111);

    // COUNT: enters cleared, counts SOP rising edges, wraps with sticky ovf.
    press_mode("enter_count", 4'b0000);
    sw = 4'b0100;
    tick(10);
    check_eq("count_idle", leds, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      logic [3:0] exp;
      exp = {(i >= 8) ? 1'b1 : 1'b0, 3'(i % 8)};
      sw = 4'b0101;
      tick(7);
      check_eq($sformatf("count_%0d", i), leds, exp);
      tick(3);
      sw = 4'b0100;
      tick(10);
      check_eq($sformatf("count_hold_%0d", i), leds, exp);
    end

    // COUNT -> LIVE -> HOLD, then mode edge coinciding with SOP rising edge.
    press_mode("count_to_live", 4'b0000);
    press_mode("live_to_hold", 4'b1000);
    sw_mode = 1'b1;
    sw      = 4'b0101;
    tick(7);
    check_eq("coincide_entry", leds, 4'b0000);
    tick(10);
    check_eq("coincide_later", leds, 4'b0000);
    sw_mode = 1'b0;
    tick(10);
    press_mode("count_to_live2", 4'b0111);

    // Asynchronous reset mid-cycle while in COUNT with an LED lit.
    press_mode("to_hold2", 4'b1111);
    press_mode("to_count2", 4'b0000);
    sw = 4'b0100;
    tick(10);
    sw = 4'b0101;
    tick(7);
    check_eq("count_before_rst", leds, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", leds, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    check_eq("post_rst_live", leds, 4'b0101);
    tick(6);
    check_eq("post_rst_latency", leds, 4'b0111);
    press_mode("post_rst_to_hold", 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
